// File: rtl/hpm_overflow_unit.sv
`default_nettype none
// ============================================================================
// Module   : hpm_overflow_unit
// Purpose  : Per-counter overflow (OF) flags, sticky LCOFI request and the
//            OF/scountovf read view for the programmable HPM counters.
// Revision : 1.0 - initial release
// ============================================================================

package config_pkg;
    typedef struct packed {
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 64};
endpackage

module hpm_overflow_unit #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg     = config_pkg::cva6_cfg_empty,
    parameter int unsigned           NumCounters = 6
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                debug_mode_i,
    input  logic [11:0]                         addr_i,
    input  logic                                we_i,
    input  logic [CVA6Cfg.XLEN-1:0]             data_i,
    output logic [CVA6Cfg.XLEN-1:0]             data_o,
    input  logic [NumCounters-1:0][63:0]        counter_q_i,
    input  logic [NumCounters-1:0]              counter_inc_i,
    input  logic                                lcofi_clr_i,
    output logic [NumCounters-1:0]              of_o,
    output logic                                lcofi_o
);

    localparam int unsigned c_xlen           = CVA6Cfg.XLEN;
    localparam bit          c_is_rv32        = (c_xlen == 32);
    localparam logic [11:0] c_cnt_base       = 12'hB03;
    localparam logic [11:0] c_cnth_base      = 12'hB83;
    localparam logic [11:0] c_evt_base       = c_is_rv32 ? 12'h723 : 12'h323;
    localparam logic [11:0] c_scountovf_addr = 12'hDA0;

    logic [NumCounters-1:0] r_of;
    logic                   r_lcofi;
    logic [NumCounters-1:0] w_cwr;
    logic [NumCounters-1:0] w_ovf;
    logic [NumCounters-1:0] w_evt_wr;
    logic [NumCounters-1:0] w_of_d;
    logic                   w_lcofi_set;
    logic                   w_of_wdata;
    logic                   w_unused_data;

    // Only the top bit of the write data carries the OF field.
    assign w_of_wdata    = data_i[c_xlen-1];
    assign w_unused_data = ^data_i[c_xlen-2:0];

    for (genvar k = 0; k < NumCounters; k++) begin : g_counter
        localparam logic [11:0] c_cnt_addr  = c_cnt_base  + 12'(k);
        localparam logic [11:0] c_cnth_addr = c_cnth_base + 12'(k);
        localparam logic [11:0] c_evt_addr  = c_evt_base  + 12'(k);

        // A software write to the counter (either half on RV32) masks the wrap.
        assign w_cwr[k] = we_i & ((addr_i == c_cnt_addr) |
                                  (c_is_rv32 & (addr_i == c_cnth_addr)));

        assign w_ovf[k] = counter_inc_i[k] & (&counter_q_i[k]) &
                          ~debug_mode_i & ~w_cwr[k];

        assign w_evt_wr[k] = we_i & (addr_i == c_evt_addr);

        // Hardware overflow takes priority over a same-cycle software write.
        assign w_of_d[k] = w_ovf[k]    ? 1'b1       :
                           w_evt_wr[k] ? w_of_wdata : r_of[k];
    end

    // Only a 0->1 OF transition raises the interrupt.
    assign w_lcofi_set = |(w_ovf & ~r_of);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_of    <= '0;
            r_lcofi <= 1'b0;
        end else begin
            r_of    <= w_of_d;
            r_lcofi <= w_lcofi_set | (r_lcofi & ~lcofi_clr_i);
        end
    end

    always_comb begin
        data_o = '0;
        if (addr_i == c_scountovf_addr) begin
            for (int k = 0; k < int'(NumCounters); k++) begin
                data_o[3+k] = r_of[k];
            end
        end
        for (int k = 0; k < int'(NumCounters); k++) begin
            if (addr_i == (c_evt_base + 12'(k))) begin
                data_o[c_xlen-1] = r_of[k];
            end
        end
    end

    assign of_o    = r_of;
    assign lcofi_o = r_lcofi;

endmodule

`default_nettype wire

// File: tb/tb_hpm_overflow_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hpm_overflow_unit
// Purpose  : Self-checking bench for hpm_overflow_unit, RV64 and RV32 builds.
// Revision : 1.0 - initial release
// ============================================================================

module tb_hpm_overflow_unit;

    localparam int                     c_n     = 6;
    localparam config_pkg::cva6_cfg_t  c_cfg32 = '{XLEN: 32};
    localparam logic [63:0]            c_ones  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0]            c_b63   = 64'h8000_0000_0000_0000;

    logic                  clk;
    logic                  rst_n;
    logic                  dbg;
    logic                  we;
    logic                  clr;
    logic [11:0]           addr;
    logic [63:0]           data;
    logic [c_n-1:0]        inc;
    logic [c_n-1:0][63:0]  cq;

    logic [63:0]           rd64;
    logic [31:0]           rd32;
    logic [c_n-1:0]        of64;
    logic [c_n-1:0]        of32;
    logic                  lc64;
    logic                  lc32;

    int n_checks;
    int n_errors;

    // Reference state: index 0 = RV64 build, index 1 = RV32 build.
    bit m_of [2][c_n];
    bit m_lc [2];

    typedef struct {
        string        name;
        logic [c_n-1:0] inc;
        logic [63:0]  cval;
        bit           dbg;
        bit           clr;
        bit           we;
        logic [11:0]  addr;
        logic [63:0]  data;
        logic [63:0]  exp_rd;
        logic [c_n-1:0] exp_of;
        bit           exp_lc;
    } vec_t;

    vec_t vq[$];

    hpm_overflow_unit #(.NumCounters(c_n)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(dbg), .addr_i(addr),
        .we_i(we), .data_i(data), .data_o(rd64), .counter_q_i(cq),
        .counter_inc_i(inc), .lcofi_clr_i(clr), .of_o(of64), .lcofi_o(lc64)
    );

    hpm_overflow_unit #(.CVA6Cfg(c_cfg32), .NumCounters(c_n)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(dbg), .addr_i(addr),
        .we_i(we), .data_i(data[31:0]), .data_o(rd32), .counter_q_i(cq),
        .counter_inc_i(inc), .lcofi_clr_i(clr), .of_o(of32), .lcofi_o(lc32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [c_n-1:0] i_inc, input logic [63:0] cval, input bit i_dbg,
                         input bit i_clr, input bit i_we, input logic [11:0] i_addr,
                         input logic [63:0] i_data);
        inc  = i_inc;
        dbg  = i_dbg;
        clr  = i_clr;
        we   = i_we;
        addr = i_addr;
        data = i_data;
        for (int k = 0; k < c_n; k++) cq[k] = cval;
    endtask

    task automatic add_vec(input string name, input logic [c_n-1:0] i_inc, input logic [63:0] cval,
                           input bit i_dbg, input bit i_clr, input bit i_we,
                           input logic [11:0] i_addr, input logic [63:0] i_data,
                           input logic [63:0] exp_rd, input logic [c_n-1:0] exp_of,
                           input bit exp_lc);
        vec_t v;
        v.name = name; v.inc = i_inc; v.cval = cval; v.dbg = i_dbg; v.clr = i_clr;
        v.we = i_we; v.addr = i_addr; v.data = i_data; v.exp_rd = exp_rd;
        v.exp_of = exp_of; v.exp_lc = exp_lc;
        vq.push_back(v);
    endtask

    task automatic model_reset();
        for (int x = 0; x < 2; x++) begin
            m_lc[x] = 0;
            for (int k = 0; k < c_n; k++) m_of[x][k] = 0;
        end
    endtask

    function automatic logic [63:0] model_rd(input int x, input logic [11:0] a);
        logic [63:0] r;
        r = '0;
        if (a == 12'hDA0) begin
            for (int k = 0; k < c_n; k++) if (m_of[x][k]) r = r + (64'd1 << (3 + k));
        end else begin
            for (int k = 0; k < c_n; k++) begin
                if (a == ((x == 1) ? 12'h723 : 12'h323) + 12'(k) && m_of[x][k])
                    r = (x == 1) ? 64'h8000_0000 : c_b63;
            end
        end
        return r;
    endfunction

    // Applies the current bench inputs to the reference state for one clock.
    task automatic model_clock(input int x);
        bit nxt [c_n];
        bit raise;
        bit wbit;
        raise = 0;
        wbit  = (x == 1) ? data[31] : data[63];
        for (int k = 0; k < c_n; k++) begin
            bit sw_cnt, ov;
            sw_cnt = we && (addr == 12'hB03 + 12'(k) || (x == 1 && addr == 12'hB83 + 12'(k)));
            ov = inc[k] && (cq[k] == c_ones) && !dbg && !sw_cnt;
            if (ov) begin
                nxt[k] = 1;
                if (!m_of[x][k]) raise = 1;
            end else if (we && addr == ((x == 1) ? 12'h723 : 12'h323) + 12'(k)) begin
                nxt[k] = wbit;
            end else begin
                nxt[k] = m_of[x][k];
            end
        end
        for (int k = 0; k < c_n; k++) m_of[x][k] = nxt[k];
        m_lc[x] = raise || (m_lc[x] && !clr);
    endtask

    function automatic logic [c_n-1:0] model_of(input int x);
        logic [c_n-1:0] v;
        for (int k = 0; k < c_n; k++) v[k] = m_of[x][k];
        return v;
    endfunction

    task automatic do_reset();
        drive('0, '0, 0, 0, 0, 12'h000, '0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        drive('0, '0, 0, 0, 0, 12'h000, '0);
        @(negedge clk);
        do_reset();

        check("reset_of64", 64'(of64), 64'd0);
        check("reset_lc64", 64'(lc64), 64'd0);
        check("reset_of32", 64'(of32), 64'd0);
        check("reset_lc32", 64'(lc32), 64'd0);

        //       name          inc        cval                   dbg clr we addr     data    exp_rd        exp_of     lc
        add_vec("idle",        6'b000000, c_ones,                0, 0, 0, 12'hDA0, '0,     64'h0,        6'b000000, 0);
        add_vec("ovf0",        6'b000001, c_ones,                0, 0, 0, 12'hDA0, '0,     64'h0,        6'b000001, 1);
        add_vec("rd_scovf",    6'b000000, c_ones,                0, 0, 0, 12'hDA0, '0,     64'h8,        6'b000001, 1);
        add_vec("clr_lcofi",   6'b000000, c_ones,                0, 1, 0, 12'h323, '0,     c_b63,        6'b000001, 0);
        add_vec("reovf0",      6'b000001, c_ones,                0, 0, 0, 12'hDA0, '0,     64'h8,        6'b000001, 0);
        add_vec("sw_clr0",     6'b000000, '0,                    0, 0, 1, 12'h323, '0,     c_b63,        6'b000000, 0);
        add_vec("ovf_wins",    6'b000010, c_ones,                0, 0, 1, 12'h324, '0,     64'h0,        6'b000010, 1);
        add_vec("set_wins",    6'b000100, c_ones,                0, 1, 0, 12'hDA0, '0,     64'h10,       6'b000110, 1);
        add_vec("clr_only",    6'b000000, c_ones,                0, 1, 0, 12'hDA0, '0,     64'h30,       6'b000110, 0);
        add_vec("cwr_mask",    6'b001000, c_ones,                0, 0, 1, 12'hB06, '0,     64'h0,        6'b000110, 0);
        add_vec("dbg_mask",    6'b001000, c_ones,                1, 0, 0, 12'h000, '0,     64'h0,        6'b000110, 0);
        add_vec("low32_ones",  6'b001000, 64'h0000_0000_FFFF_FFFF,0,0, 0, 12'h000, '0,     64'h0,        6'b000110, 0);
        add_vec("wr_scovf",    6'b000000, '0,                    0, 0, 1, 12'hDA0, c_ones, 64'h30,       6'b000110, 0);
        add_vec("multi_ovf",   6'b111001, c_ones,                0, 0, 0, 12'h325, '0,     c_b63,        6'b111111, 1);
        add_vec("sw_clr3",     6'b000000, '0,                    0, 0, 1, 12'h326, '0,     c_b63,        6'b110111, 1);
        add_vec("sw_set3",     6'b000000, '0,                    0, 1, 1, 12'h326, c_b63,  64'h0,        6'b111111, 0);
        add_vec("rv32_addr",   6'b000000, '0,                    0, 0, 1, 12'h723, '0,     64'h0,        6'b111111, 0);

        foreach (vq[i]) begin
            drive(vq[i].inc, vq[i].cval, vq[i].dbg, vq[i].clr, vq[i].we, vq[i].addr, vq[i].data);
            #1;
            check({vq[i].name, "_rd"}, rd64, vq[i].exp_rd);
            @(posedge clk);
            #1;
            check({vq[i].name, "_of"}, 64'(of64), 64'(vq[i].exp_of));
            check({vq[i].name, "_lc"}, 64'(lc64), 64'(vq[i].exp_lc));
            @(negedge clk);
        end

        // RV32 build: eventh OF bit, high-half counter write mask, async reset.
        do_reset();
        drive(6'b100000, c_ones, 0, 0, 0, 12'h000, '0);
        @(posedge clk); #1;
        check("rv32_ovf5_of", 64'(of32), 64'(6'b100000));
        check("rv32_ovf5_lc", 64'(lc32), 64'd1);
        @(negedge clk);
        drive('0, '0, 0, 0, 0, 12'h728, '0);
        #1;
        check("rv32_rd728", 64'(rd32), 64'h8000_0000);
        drive('0, '0, 0, 0, 1, 12'h728, '0);
        @(posedge clk); #1;
        check("rv32_wr728_of", 64'(of32), 64'd0);
        check("rv64_ign728_of", 64'(of64), 64'(6'b100000));
        @(negedge clk);
        drive(6'b100000, c_ones, 0, 0, 1, 12'hB88, '0);
        @(posedge clk); #1;
        check("rv32_cwrh_of", 64'(of32), 64'd0);
        @(negedge clk);
        drive(6'b000001, c_ones, 0, 0, 0, 12'hDA0, '0);
        @(posedge clk); #1;
        check("rv32_pre_rst_of", 64'(of32), 64'(6'b000001));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_of32", 64'(of32), 64'd0);
        check("async_lc32", 64'(lc32), 64'd0);
        check("async_of64", 64'(of64), 64'd0);
        check("async_lc64", 64'(lc64), 64'd0);
        check("async_rd32", 64'(rd32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int c = 0; c < 400; c++) begin
            logic [11:0] a;
            int          k;
            int          sel;
            k   = $urandom_range(0, c_n - 1);
            sel = $urandom_range(0, 7);
            case (sel)
                0:       a = 12'hB03 + 12'(k);
                1:       a = 12'hB83 + 12'(k);
                2, 6:    a = 12'h323 + 12'(k);
                3, 7:    a = 12'h723 + 12'(k);
                4:       a = 12'hDA0;
                default: a = 12'($urandom);
            endcase
            addr = a;
            we   = ($urandom_range(0, 2) == 0);
            data = {$urandom, $urandom};
            inc  = c_n'($urandom);
            dbg  = ($urandom_range(0, 9) == 0);
            clr  = ($urandom_range(0, 3) == 0);
            for (int j = 0; j < c_n; j++) begin
                case ($urandom_range(0, 3))
                    0, 1:    cq[j] = c_ones;
                    2:       cq[j] = 64'h0000_0000_FFFF_FFFF;
                    default: cq[j] = {$urandom, $urandom};
                endcase
            end
            #1;
            check("rnd_rd64", rd64, model_rd(0, addr));
            check("rnd_rd32", 64'(rd32), model_rd(1, addr));
            @(posedge clk);
            model_clock(0);
            model_clock(1);
            #1;
            check("rnd_of64", 64'(of64), 64'(model_of(0)));
            check("rnd_lc64", 64'(lc64), 64'(m_lc[0]));
            check("rnd_of32", 64'(of32), 64'(model_of(1)));
            check("rnd_lc32", 64'(lc32), 64'(m_lc[1]));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
